// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for the 16-bit core.
// Owns the fetch PC and drives a ready-based request to instruction memory.
// Accepted words go into an output register, which is backed by a one-entry
// skid buffer so that a word arriving during a stall is not lost. A redirect
// flushes everything downstream. If a request is still outstanding when the
// redirect arrives, that request is drained first so that the memory handshake
// stays legal. Fetching stops after an HLT word (opcode 4'hF) until a redirect.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic [15:0] instr_out,
  output logic [15:0] pc_out,
  output logic [15:0] pc_plus2,
  output logic        instr_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [15:0] pc;
  logic [15:0] drain_addr;

  logic [15:0] skid_instr;
  logic [15:0] skid_pc;
  logic        skid_valid;

  logic        run_fire;
  logic        accept;
  logic        is_hlt;
  logic        load_out;
  logic        stale_pending;

  // Handshake qualifiers shared by the FSM and the datapath registers
  always_comb begin
    run_fire      = (state == RUN) && imem_req && imem_rdy;
    accept        = run_fire && !redirect;
    is_hlt        = (imem_data[15:12] == 4'hF);
    load_out      = !instr_valid || !stall;
    stale_pending = (state == RUN) && imem_req && !imem_rdy;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // FSM next state: redirect dominates, with a stale request forcing a drain
  always_comb begin
    next_state = state;
    case (state)
      RUN: begin
        if (redirect) begin
          if (stale_pending) begin
            next_state = DRAIN;
          end else begin
            next_state = RUN;
          end
        end else if (accept && is_hlt) begin
          next_state = HALT;
        end
      end
      DRAIN: begin
        if (redirect) begin
          next_state = DRAIN;
        end else if (imem_rdy) begin
          next_state = RUN;
        end
      end
      HALT: begin
        if (redirect) begin
          next_state = RUN;
        end
      end
      default: begin
        next_state = RUN;
      end
    endcase
  end

  // FSM outputs: request/address selection and the halted flag
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    halted    = 1'b0;
    case (state)
      RUN: begin
        imem_req  = !skid_valid;
        imem_addr = pc;
      end
      DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
    if (rst) begin
      imem_req = 1'b0;
    end
  end

  // Fetch PC: redirect target, otherwise advance by one word on each accepted fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (accept) begin
      pc <= pc + 16'd2;
    end
  end

  // Remember the address of the abandoned request so it stays stable until imem_rdy
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_addr <= 16'h0000;
    end else if (redirect && stale_pending) begin
      drain_addr <= pc;
    end
  end

  // Output register toward decode: skid word first, then a fresh fetch, else bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_out   <= 16'h0000;
      pc_out      <= 16'h0000;
      pc_plus2    <= 16'h0000;
      instr_valid <= 1'b0;
    end else if (redirect) begin
      instr_valid <= 1'b0;
    end else if (load_out) begin
      if (skid_valid) begin
        instr_out   <= skid_instr;
        pc_out      <= skid_pc;
        pc_plus2    <= skid_pc + 16'd2;
        instr_valid <= 1'b1;
      end else if (accept) begin
        instr_out   <= imem_data;
        pc_out      <= pc;
        pc_plus2    <= pc + 16'd2;
        instr_valid <= 1'b1;
      end else begin
        instr_valid <= 1'b0;
      end
    end
  end

  // Skid buffer: catches the word accepted while the output register is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_instr <= 16'h0000;
      skid_pc    <= 16'h0000;
      skid_valid <= 1'b0;
    end else if (redirect) begin
      skid_valid <= 1'b0;
    end else if (load_out && skid_valid) begin
      skid_valid <= 1'b0;
    end else if (accept && !load_out) begin
      skid_instr <= imem_data;
      skid_pc    <= pc;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed, table-driven bench for fetch_stage.
// Memory responses are scripted per cycle in the vector table. Each row
// holds the inputs for one cycle and the outputs expected in that cycle,
// sampled shortly after the falling edge.
module tb_fetch_stage;

  typedef struct {
    logic        sel;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        rdy;
    logic [15:0] data;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_instr;
    logic [15:0] exp_pc;
    logic [15:0] exp_pc2;
    logic        exp_halted;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_rdy;
  logic [15:0] imem_data;

  logic        d0_req, d0_valid, d0_halted;
  logic [15:0] d0_addr, d0_instr, d0_pc, d0_pc2;
  logic        d1_req, d1_valid, d1_halted;
  logic [15:0] d1_addr, d1_instr, d1_pc, d1_pc2;

  int vectors     = 0;
  int miscompares = 0;

  vec_t vecs[$];

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(16'h0000)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(d0_req), .imem_addr(d0_addr),
    .imem_rdy(imem_rdy), .imem_data(imem_data), .instr_out(d0_instr),
    .pc_out(d0_pc), .pc_plus2(d0_pc2), .instr_valid(d0_valid), .halted(d0_halted)
  );

  fetch_stage #(.RESET_PC(16'hFFFE)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(d1_req), .imem_addr(d1_addr),
    .imem_rdy(imem_rdy), .imem_data(imem_data), .instr_out(d1_instr),
    .pc_out(d1_pc), .pc_plus2(d1_pc2), .instr_valid(d1_valid), .halted(d1_halted)
  );

  function automatic vec_t mk(
    input logic sel, input logic r, input logic st, input logic rd,
    input logic [15:0] rpc, input logic rdy, input logic [15:0] data,
    input logic ereq, input logic [15:0] eaddr, input logic evalid,
    input logic [15:0] einstr, input logic [15:0] epc, input logic [15:0] epc2,
    input logic ehalt);
    vec_t v;
    v.sel = sel; v.rst = r; v.stall = st; v.redirect = rd; v.redirect_pc = rpc;
    v.rdy = rdy; v.data = data; v.exp_req = ereq; v.exp_addr = eaddr;
    v.exp_valid = evalid; v.exp_instr = einstr; v.exp_pc = epc; v.exp_pc2 = epc2;
    v.exp_halted = ehalt;
    return v;
  endfunction

  task automatic compare(input string name, input int idx,
                         input logic [15:0] got, input logic [15:0] exp);
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s vec %0d: got %h, expected %h", name, idx, got, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    logic        req, valid, hlt;
    logic [15:0] addr, instr, pc, pc2;
    if (v.sel) begin
      req = d1_req; valid = d1_valid; hlt = d1_halted;
      addr = d1_addr; instr = d1_instr; pc = d1_pc; pc2 = d1_pc2;
    end else begin
      req = d0_req; valid = d0_valid; hlt = d0_halted;
      addr = d0_addr; instr = d0_instr; pc = d0_pc; pc2 = d0_pc2;
    end
    vectors++;
    compare("imem_req", idx, 16'(req), 16'(v.exp_req));
    if (v.exp_req) compare("imem_addr", idx, addr, v.exp_addr);
    compare("instr_valid", idx, 16'(valid), 16'(v.exp_valid));
    compare("halted", idx, 16'(hlt), 16'(v.exp_halted));
    if (v.exp_valid) begin
      compare("instr_out", idx, instr, v.exp_instr);
      compare("pc_out", idx, pc, v.exp_pc);
      compare("pc_plus2", idx, pc2, v.exp_pc2);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    rst         = v.rst;
    stall       = v.stall;
    redirect    = v.redirect;
    redirect_pc = v.redirect_pc;
    imem_rdy    = v.rdy;
    imem_data   = v.data;
    #1;
    checkOutput(v, idx);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    imem_rdy = 1'b0; imem_data = 16'h0000;

    // zero-wait fetch from 0: pc_out 0,2,4,6
    vecs.push_back(mk(0,0,0,0,16'h0,1,16'h1000, 1,16'h0000, 0,16'h0,16'h0,16'h0, 0));
    vecs.push_back(mk(0,0,0,0,16'h0,1,16'h1002, 1,16'h0002, 1,16'h1000,16'h0000,16'h0002, 0));
    vecs.push_back(mk(0,0,0,0,16'h0,1,16'h1004, 1,16'h0004, 1,16'h1002,16'h0002,16'h0004, 0));
    vecs.push_back(mk(0,0,0,0,16'h0,1,16'h1006, 1,16'h0006, 1,16'h1004,16'h0004,16'h0006, 0));
    // request to 0x0008 waits; redirect to 0x0040 drains it
    vecs.push_back(mk(0,0,0,0,16'h0,0,16'h0000, 1,16'h0008, 1,16'h1006,16'h0006,16'h0008, 0));
    vecs.push_back(mk(0,0,0,1,16'h0040,0,16'h0000, 1,16'h0008, 0,16'h0,16'h0,16'h0, 0));
    vecs.push_back(mk(0,0,0,0,16'h0,0,16'h0000, 1,16'h0008, 0,16'h0,16'h0,16'h0, 0));
    vecs.push_back(mk(0,0,0,0,16'h0,1,16'h1008, 1,16'h0008, 0,16'h0,16'h0,16'h0, 0));
    // 3-cycle memory on 0x0040 and 0x0042
    vecs.push_back(mk(0,0,0,0,16'h0,0,16'h0000, 1,16'h0040, 0,16'h0,16'h0,16'h0, 0));
    vecs.push_back(mk(0,0,0,0,16'h0,0,16'h0000, 1,16'h0040, 0,16'h0,16'h0,16'h0, 0));
    vecs.push_back(mk(0,0,0,0,16'h0,1,16'h1040, 1,16'h0040, 0,16'h0,16'h0,16'h0, 0));
    vecs.push_back(mk(0,0,0,0,16'h0,0,16'h0000, 1,16'h0042, 1,16'h1040,16'h0040,16'h0042, 0));
    vecs.push_back(mk(0,0,0,0,16'h0,0,16'h0000, 1,16'h0042, 0,16'h0,16'h0,16'h0, 0));
    vecs.push_back(mk(0,0,0,0,16'h0,1,16'h1042, 1,16'h0042, 0,16'h0,16'h0,16'h0, 0));
    // stall for 3 cycles: 0x0044 goes to skid, requests blocked
    vecs.push_back(mk(0,0,1,0,16'h0,1,16'h1044, 1,16'h0044, 1,16'h1042,16'h0042,16'h0044, 0));
    vecs.push_back(mk(0,0,1,0,16'h0,1,16'h1046, 0,16'h0000, 1,16'h1042,16'h0042,16'h0044, 0));
    vecs.push_back(mk(0,0,1,0,16'h0,1,16'h1046, 0,16'h0000, 1,16'h1042,16'h0042,16'h0044, 0));
    vecs.push_back(mk(0,0,0,0,16'h0,1,16'h1046, 0,16'h0000, 1,16'h1042,16'h0042,16'h0044, 0));
    vecs.push_back(mk(0,0,0,0,16'h0,1,16'h1046, 1,16'h0046, 1,16'h1044,16'h0044,16'h0046, 0));
    vecs.push_back(mk(0,0,0,0,16'h0,0,16'h0000, 1,16'h0048, 1,16'h1046,16'h0046,16'h0048, 0));
    // redirect and imem_rdy together: data dropped, fetch 0x0008
    vecs.push_back(mk(0,0,0,1,16'h0008,1,16'h1048, 1,16'h0048, 0,16'h0,16'h0,16'h0, 0));
    vecs.push_back(mk(0,0,0,0,16'h0,1,16'h1008, 1,16'h0008, 0,16'h0,16'h0,16'h0, 0));
    // HLT word at 0x000A
    vecs.push_back(mk(0,0,0,0,16'h0,1,16'hF000, 1,16'h000A, 1,16'h1008,16'h0008,16'h000A, 0));
    vecs.push_back(mk(0,0,0,0,16'h0,1,16'h100C, 0,16'h0000, 1,16'hF000,16'h000A,16'h000C, 1));
    vecs.push_back(mk(0,0,0,0,16'h0,1,16'h100C, 0,16'h0000, 0,16'h0,16'h0,16'h0, 1));
    vecs.push_back(mk(0,0,0,1,16'h0020,0,16'h0000, 0,16'h0000, 0,16'h0,16'h0,16'h0, 1));
    vecs.push_back(mk(0,0,0,0,16'h0,1,16'h1020, 1,16'h0020, 0,16'h0,16'h0,16'h0, 0));
    vecs.push_back(mk(0,0,0,0,16'h0,1,16'h1022, 1,16'h0022, 1,16'h1020,16'h0020,16'h0022, 0));
    // stall and redirect together: flush still happens
    vecs.push_back(mk(0,0,1,1,16'h0060,1,16'h1024, 1,16'h0024, 1,16'h1022,16'h0022,16'h0024, 0));
    vecs.push_back(mk(0,0,1,0,16'h0,1,16'h1060, 1,16'h0060, 0,16'h0,16'h0,16'h0, 0));
    vecs.push_back(mk(0,0,1,0,16'h0,0,16'h0000, 1,16'h0062, 1,16'h1060,16'h0060,16'h0062, 0));
    vecs.push_back(mk(0,0,0,0,16'h0,0,16'h0000, 1,16'h0062, 1,16'h1060,16'h0060,16'h0062, 0));

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    vectors++;
    compare("reset imem_req", -1, 16'(d0_req), 16'h0000);
    compare("reset instr_valid", -1, 16'(d0_valid), 16'h0000);
    compare("reset halted", -1, 16'(d0_halted), 16'h0000);
    compare("reset instr_out", -1, d0_instr, 16'h0000);
    compare("reset pc_out", -1, d0_pc, 16'h0000);
    compare("reset pc_plus2", -1, d0_pc2, 16'h0000);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
    end

    // wrap from RESET_PC=FFFE and reset in the middle of a wait
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; imem_rdy = 1'b0;
    repeat (2) @(posedge clk);
    applyStimulus(mk(1,0,0,0,16'h0,1,16'h2FFE, 1,16'hFFFE, 0,16'h0,16'h0,16'h0, 0), 100);
    applyStimulus(mk(1,0,0,0,16'h0,1,16'h2000, 1,16'h0000, 1,16'h2FFE,16'hFFFE,16'h0000, 0), 101);
    applyStimulus(mk(1,0,1,0,16'h0,0,16'h0000, 1,16'h0002, 1,16'h2000,16'h0000,16'h0002, 0), 102);
    applyStimulus(mk(1,1,0,0,16'h0,0,16'h0000, 0,16'h0000, 1,16'h2000,16'h0000,16'h0002, 0), 103);
    applyStimulus(mk(1,0,0,0,16'h0,0,16'h0000, 1,16'hFFFE, 0,16'h0,16'h0,16'h0, 0), 104);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the 16-bit core. It owns the fetch PC and issues requests to instruction memory over a ready-based handshake. Returned instructions go into an output register, backed by a one-entry skid buffer, which feeds the IF/ID boundary. It also handles branch redirects, downstream stalls and HLT detection, and is the producer of the next-PC value the core's PC register tracks.

## Interface
- RESET_PC, default 16'h0000, PC loaded on reset.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  downstream cannot accept; output register holds.
- redirect  in  1  taken branch/jump resolved downstream; flush and refetch.
- redirect_pc  in  16  target address, valid with redirect.
- imem_req  out  1  fetch request; address held stable until imem_rdy.
- imem_addr  out  16  fetch address.
- imem_rdy  in  1  imem_data valid, request complete; sampled only while imem_req=1.
- imem_data  in  16  fetched instruction word.
- instr_out  out  16  registered instruction to decode.
- pc_out  out  16  address of instr_out.
- pc_plus2  out  16  pc_out + 2, mod 2^16.
- instr_valid  out  1  instr_out/pc_out/pc_plus2 are valid.
- halted  out  1  fetch stopped on HLT (opcode 4'hF).

## Operation
- State: fetch pc (16b), drain_addr (16b), FSM {RUN, DRAIN, HALT}, output register, skid register {instr, pc} + skid_valid.
- Reset values: pc=RESET_PC, FSM=RUN, instr_valid=0, skid_valid=0, halted=0, instr_out/pc_out/pc_plus2=0, imem_req=0 while rst=1.
- RUN:
  - imem_req = !skid_valid, imem_addr = pc.
  - On imem_rdy: the instruction is accepted and pc <= pc+2; wraps 16'hFFFE -> 16'h0000.
  - If imem_data[15:12]==4'hF, FSM -> HALT.
- DRAIN: imem_req=1, imem_addr=drain_addr. On imem_rdy, discard the data and FSM -> RUN.
- HALT:
  - imem_req=0, halted=1.
  - The output register and skid buffer still drain normally.
  - Only redirect or rst leaves HALT.
- Output register update, when !instr_valid || !stall:
  - If skid_valid: load from skid, skid_valid <= 0.
  - Else if an accepted fetch occurs this cycle: load {imem_data, pc}, instr_valid <= 1.
  - Else instr_valid <= 0.
- Skid: an accepted fetch while instr_valid && stall goes to skid, skid_valid <= 1. New requests are blocked until the skid drains.
- Redirect has highest priority and is applied regardless of stall:
  - instr_valid <= 0, skid_valid <= 0, pc <= redirect_pc, halted <= 0.
  - RUN with imem_req=1 and !imem_rdy: drain_addr <= pc, FSM -> DRAIN.
  - RUN with imem_rdy, or RUN with no outstanding request: data discarded, FSM stays RUN.
  - DRAIN: stays DRAIN; pc takes the newest redirect_pc.
  - HALT: FSM -> RUN.
- A HLT word is delivered downstream like any other instruction. Words fetched after HLT are never requested.

## Timing
- The first request is issued in the first cycle after rst deasserts, with imem_addr=RESET_PC.
- Zero-wait memory (imem_rdy in the same cycle as imem_req): one instruction per cycle. instr_valid rises one cycle after the accepting edge.
- Latency: accepting edge -> instr_out valid on the next cycle.
- A redirect asserted in cycle N affects cycle N+1:
  - Outputs are flushed.
  - With no outstanding request, imem_addr = redirect_pc.
  - Otherwise the stale request completes first, then redirect_pc is requested in the cycle after its imem_rdy.
- Redirect and imem_rdy in the same cycle: redirect wins and the data is dropped.
- Stall and redirect in the same cycle: the flush still occurs.
- Reset mid-transaction: the outstanding request is abandoned. The memory must accept imem_req dropping.

## Test plan
- Zero-wait memory returning 16'h1000+addr from RESET_PC=0, no stall -> pc_out 0,2,4,6 on consecutive cycles, pc_plus2 2,4,6,8, instr_valid held at 1.
- 3-cycle memory latency -> imem_addr held at 0x0002 for 3 cycles; each instruction appears 1 cycle after its imem_rdy.
- Stall held 3 cycles with zero-wait memory -> output frozen, one word captured in skid, imem_req=0; on release the skid word appears next cycle and fetch resumes at the following address.
- Redirect to 0x0040 while the request to 0x0008 is waiting -> 0x0008 completes and is discarded; next request is 0x0040; no instruction from 0x0008 reaches instr_out.
- Word 16'hF000 fetched at 0x000A -> delivered with pc_out=0x000A, halted=1, imem_req=0 thereafter; a later redirect to 0x0020 clears halted and fetches 0x0020.
- RESET_PC=16'hFFFE -> pc_out FFFE then 0000 (wrap); rst pulsed mid-wait -> next cycle shows instr_valid=0 and a request to FFFE.
